// File: rtl/pilha_lifo_if.sv
// Deserializer -> stack 4-phase handshake: word + ready from the sender,
// ack back from the stack.
interface pilha_lifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_ready_in;
  logic             ack_out;

  modport master (output data_in, output data_ready_in, input ack_out);
  modport slave  (input data_in, input data_ready_in, output ack_out);
endinterface

// File: rtl/pilha_lifo.sv
// LIFO stack fed by the deserializer over an asynchronous 4-phase handshake,
// drained newest-first by a local synchronous pop request.

// Multi-flop synchronizer for a single asynchronous level.
module pilha_lifo_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[STAGES-1];
endmodule

module pilha_lifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  pilha_lifo_if.slave                des,
  input  logic                       pop_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       pop_err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACK_WAIT} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
  logic [CW-1:0]                r_count;
  logic [WIDTH-1:0]             r_dout;
  logic                         r_dv;
  logic                         r_perr;

  logic          w_rdy_s;
  logic          w_push;
  logic          w_pop;
  logic          w_push_ok;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_wr_idx;

  // data_in is not synchronized: it is only sampled once rdy_s is high,
  // by which point the sender has held it stable for several cycles.
  pilha_lifo_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (des.data_ready_in),
    .o_sync  (w_rdy_s)
  );

  assign w_pop     = pop_in && (r_count != '0);
  assign w_push_ok = (r_count < CW'(DEPTH)) || w_pop;
  assign w_top_idx = AW'(r_count - CW'(1));
  // On a simultaneous push/pop the new word replaces the old top in place.
  assign w_wr_idx  = w_pop ? w_top_idx : AW'(r_count);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rdy_s && w_push_ok) begin
          w_push      = 1'b1;
          w_state_nxt = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (!w_rdy_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage has no reset; stale entries are never observable past count.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[w_wr_idx] <= des.data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_dv   <= w_pop;
      r_perr <= pop_in && (r_count == '0);
      if (w_pop) r_dout <= r_mem[w_top_idx];
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign des.ack_out    = (r_state == ACK_WAIT);
  assign data_out       = r_dout;
  assign data_valid_out = r_dv;
  assign count          = r_count;
  assign pop_err        = r_perr;
  assign empty          = (r_count == '0);
  assign full           = (r_count == CW'(DEPTH));
endmodule

// File: doc/pilha_lifo.md
Name: pilha_lifo

Overview:
- LIFO stack stage directly downstream of the deserializer.
- Takes 8-bit words from the deserializer through a 4-phase data_ready/ack handshake. The two blocks run in different clock domains; the deserializer runs at 100 kHz.
- Stores words in a DEPTH-entry stack and returns them newest-first on a local pop request.
- Asserts backpressure by withholding ack when the stack is full.

Parameters:
- WIDTH, 8, word width; must match deserializer data_out.
- DEPTH, 8, number of stack entries (>=2).
- SYNC_STAGES, 2, flip-flop stages on the data_ready_in synchronizer (>=2).

Ports:
- clock  in  1  stack-domain clock.
- reset  in  1  asynchronous, active-high; clears all state.
- data_in  in  WIDTH  word from deserializer; held stable by sender while data_ready_in is high.
- data_ready_in  in  1  deserializer word-valid, asynchronous to clock.
- ack_out  out  1  word-accepted acknowledge back to the deserializer (4-phase).
- pop_in  in  1  synchronous pop request, sampled each rising edge.
- data_out  out  WIDTH  last popped word.
- data_valid_out  out  1  one-cycle pulse: data_out updated this cycle.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  $clog2(DEPTH+1)  number of stored words.
- pop_err  out  1  one-cycle pulse: pop_in while empty.

Behaviour:
- Reset (async, active-high):
  - ack_out=0, data_out=0, data_valid_out=0, pop_err=0, count=0, empty=1, full=0.
  - State=IDLE; synchronizer flops=0.
  - Memory contents are don't-care.
  - Reset mid-handshake drops ack_out immediately. The sender sees no ack and retries.
- Synchronizer: data_ready_in passes through SYNC_STAGES flops; rdy_s is the last stage. data_in is never synchronized; it is sampled only while rdy_s=1, when it is guaranteed stable.
- FSM, 2 states:
  - IDLE: if rdy_s=1 and push_ok, then on the next edge:
    - write data_in to the push slot;
    - set ack_out<=1;
    - go to ACK_WAIT.
    If rdy_s=1 and !push_ok, stay in IDLE with ack_out=0. This is backpressure; the deserializer stalls.
  - ACK_WAIT: hold ack_out=1 and ignore data_in. When rdy_s=0, on the next edge set ack_out<=0 and go to IDLE.
- Exactly one push per data_ready_in high phase.
- Push latency: ack_out rises SYNC_STAGES+1 edges after data_ready_in is sampled high. It falls SYNC_STAGES+1 edges after data_ready_in is sampled low.
- push_ok = (count<DEPTH) OR pop_accept.
- pop_accept = pop_in AND count>0. Pop is legal in either FSM state.
- Pop only:
  - data_out<=mem[count-1];
  - data_valid_out<=1 for one cycle;
  - count<=count-1.
- Push only: mem[count]<=data_in; count<=count+1.
- Push and pop on the same edge:
  - data_out<=old mem[count-1] (old top);
  - mem[count-1]<=data_in;
  - count unchanged.
  - This is also the only way to push while full.
- pop_in while empty: pop_err<=1 for one cycle; data_out and count unchanged; a simultaneous push proceeds normally.
- data_out holds its value between pops.
- Flags empty and full are combinational from count.
- count never exceeds DEPTH and never wraps below 0.

Test Plan:
- Reset, then push 0xA5 (data_ready_in high until ack_out, then low) -> ack_out rises 3 edges after data_ready_in; count=1; empty=0; ack_out falls 3 edges after data_ready_in drops.
- Push 0x11,0x22,0x33, then pop x3 -> data_out=0x33,0x22,0x11, each with a 1-cycle data_valid_out; final count=0, empty=1.
- Push 8 words 0x01..0x08 then a 9th word 0xFF -> full=1, ack_out stays 0 while data_ready_in is held. Pulse pop_in -> data_out=0x08, ack_out rises; count returns to 8, top=0xFF.
- With count=2 (top=0x22), time pop_in to the push edge for 0x77 -> data_out=0x22, data_valid_out=1, count stays 2, next pop returns 0x77.
- pop_in on an empty stack -> pop_err 1-cycle pulse; data_out keeps its previous value; count=0.
- Assert reset while in ACK_WAIT with count=3 -> ack_out=0 immediately, count=0, empty=1. Deassert reset with data_ready_in still high -> a new push of the held word occurs, count=1.
